// File: rtl/mips_muldiv_unit_if.sv
// Bus between the MIPS controller/datapath and the multiply/divide unit.
interface mips_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hilo_wr;
  logic             hilo_sel;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, hilo_wr, hilo_sel, wdata,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, hilo_wr, hilo_sel, wdata,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// One shift-add or restoring-divide step per cycle on magnitudes, then a
// single sign-fix cycle that writes HI/LO.
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  mips_muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  // MUL: running product {upper, multiplier}. DIV: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               neg_q;
  logic               rneg_q;
  logic               zero_q;
  logic               done_q;
  logic               div0_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.div0 = div0_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Operand magnitudes, per-step arithmetic and sign-fixed results
  always_comb begin
    sgn_a     = bus.op[0] & bus.a[WIDTH-1];
    sgn_b     = bus.op[0] & bus.b[WIDTH-1];
    abs_a     = sgn_a ? -bus.a : bus.a;
    abs_b     = sgn_b ? -bus.b : bus.b;
    addend    = acc_q[0] ? opnd_q : '0;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    prod_fix  = neg_q ? -acc_q : acc_q;
    quot_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: WIDTH iteration cycles, one fix cycle; flush aborts any busy state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = bus.op[1] ? S_DIV : S_MUL;
      S_MUL,
      S_DIV:  if (cnt_q == LAST) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Datapath, counter and HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            cnt_q  <= '0;
            neg_q  <= sgn_a ^ sgn_b;
            rneg_q <= sgn_a;
            zero_q <= bus.op[1] && (bus.b == '0);
            if (bus.op[1]) begin
              acc_q  <= {{WIDTH{1'b0}}, abs_a};
              opnd_q <= abs_b;
            end else begin
              acc_q  <= {{WIDTH{1'b0}}, abs_b};
              opnd_q <= abs_a;
            end
          end else if (bus.hilo_wr) begin
            if (bus.hilo_sel) hi_q <= bus.wdata;
            else              lo_q <= bus.wdata;
          end
        end
        S_MUL: begin
          cnt_q <= cnt_q + 1'b1;
          acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
        end
        S_DIV: begin
          cnt_q <= cnt_q + 1'b1;
          if (!div_diff[WIDTH])
            acc_q <= {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_q <= {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        S_FIX: begin
          if (!bus.flush) begin
            done_q <= 1'b1;
            div0_q <= zero_q;
            if (state_t'(S_DIV) == S_DIV && opnd_is_div()) begin
              // A zero divisor leaves remainder=|a|; the remainder sign fix
              // restores raw a, so only the quotient needs forcing.
              hi_q <= rem_fix;
              lo_q <= zero_q ? '1 : quot_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Remembers which kind of op is in flight for the fix cycle
  logic is_div_q;

  function automatic logic opnd_is_div();
    return is_div_q;
  endfunction

  // Operation kind latched at start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            is_div_q <= 1'b0;
    else if (state_q == S_IDLE && bus.start) is_div_q <= bus.op[1];
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: an arithmetic reference model
// checked every cycle, plus directed cases with literal expected values.
module tb_mips_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = 33;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mips_muldiv_unit_if #(.WIDTH(W)) bus ();

  mips_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic result plus a countdown to done
  logic [64:0] m_pend;
  logic [31:0] m_hi, m_lo;
  logic        m_done, m_div0;
  int          m_cnt;

  function automatic logic [64:0] calc(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [31:0]     h, l;
    logic            z;
    ux = {32'b0, x};
    uy = {32'b0, y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    z  = 1'b0;
    h  = '0;
    l  = '0;
    case (op)
      2'b00: begin ux = ux * uy; h = ux[63:32]; l = ux[31:0]; end
      2'b01: begin sx = sx * sy; h = sx[63:32]; l = sx[31:0]; end
      default: begin
        if (y == 32'd0) begin
          z = 1'b1; h = x; l = '1;
        end else if (op == 2'b10) begin
          h = 32'(ux % uy); l = 32'(ux / uy);
        end else begin
          h = 32'(sx % sy); l = 32'(sx / sy);
        end
      end
    endcase
    return {z, h, l};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend <= '0; m_hi <= '0; m_lo <= '0;
      m_done <= 1'b0; m_div0 <= 1'b0; m_cnt <= 0;
    end else begin
      m_done <= 1'b0;
      m_div0 <= 1'b0;
      if (m_cnt != 0) begin
        if (bus.flush) m_cnt <= 0;
        else begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) begin
            m_hi   <= m_pend[63:32];
            m_lo   <= m_pend[31:0];
            m_done <= 1'b1;
            m_div0 <= m_pend[64];
          end
        end
      end else if (bus.start) begin
        m_pend <= calc(bus.op, bus.a, bus.b);
        m_cnt  <= LAT;
      end else if (bus.hilo_wr) begin
        if (bus.hilo_sel) m_hi <= bus.wdata;
        else              m_lo <= bus.wdata;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1; bus.op = op; bus.a = x; bus.b = y;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts edges from the start edge until done is seen; gives up at 60
  task automatic wait_done(input int n0, output int lat);
    lat = n0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!bus.done && lat < 60);
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input logic ez);
    int lat;
    start_op(op, x, y);
    wait_done(0, lat);
    chk({nm, " latency"}, 32'(lat), 32'(LAT));
    chk({nm, " hi"}, bus.hi, eh);
    chk({nm, " lo"}, bus.lo, el);
    chk({nm, " div0"}, {31'b0, bus.div0}, {31'b0, ez});
  endtask

  initial begin
    int lat;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.flush = 1'b0; bus.hilo_wr = 1'b0; bus.hilo_sel = 1'b0; bus.wdata = '0;

    // Every-cycle comparison against the model
    fork
      forever begin
        @(negedge clk);
        chk("cmp busy", {31'b0, bus.busy}, {31'b0, m_cnt != 0});
        chk("cmp done", {31'b0, bus.done}, {31'b0, m_done});
        chk("cmp div0", {31'b0, bus.div0}, {31'b0, m_div0});
        chk("cmp hi", bus.hi, m_hi);
        chk("cmp lo", bus.lo, m_lo);
      end
    join_none

    #12;
    chk("reset busy", {31'b0, bus.busy}, 32'd0);
    chk("reset done", {31'b0, bus.done}, 32'd0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult -3*5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("mult minneg", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    run_op("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu 7/2", 2'b10, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    run_op("div minneg/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("div 7/-2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("divu 5/0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op("div -8/0", 2'b11, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);
    run_op("multu 6*7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    // MTLO then MTHI in idle, with a stray flush that must do nothing
    bus.hilo_wr = 1'b1; bus.hilo_sel = 1'b0; bus.wdata = 32'h1234; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.hilo_sel = 1'b1; bus.wdata = 32'hABCD;
    @(posedge clk); #1;
    bus.hilo_wr = 1'b0;
    chk("mtlo", bus.lo, 32'h1234);
    chk("mthi", bus.hi, 32'hABCD);

    // start and hilo_wr together in idle: start wins
    bus.hilo_wr = 1'b1; bus.hilo_sel = 1'b0; bus.wdata = 32'hDEAD;
    start_op(2'b00, 32'd6, 32'd7);
    bus.hilo_wr = 1'b0;
    wait_done(0, lat);
    chk("start wins latency", 32'(lat), 32'(LAT));
    chk("start wins lo", bus.lo, 32'd42);

    // start and MTLO in cycle 5 of a MULT are ignored
    start_op(2'b01, 32'hFFFF_FFFE, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd1; bus.b = 32'd1;
    bus.hilo_wr = 1'b1; bus.hilo_sel = 1'b0; bus.wdata = 32'hDEAD;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hilo_wr = 1'b0;
    wait_done(5, lat);
    chk("hazard latency", 32'(lat), 32'(LAT));
    chk("hazard hi", bus.hi, 32'hFFFF_FFFF);
    chk("hazard lo", bus.lo, 32'hFFFF_FFFA);

    // Flush at cycle 10: busy drops, no done, HI/LO keep pre-op values
    start_op(2'b00, 32'd9, 32'd9);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush busy", {31'b0, bus.busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush hi", bus.hi, 32'hFFFF_FFFF);
    chk("flush lo", bus.lo, 32'hFFFF_FFFA);

    // Flush on the fix edge beats completion
    start_op(2'b10, 32'd100, 32'd7);
    repeat (32) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush fix done", {31'b0, bus.done}, 32'd0);
    chk("flush fix busy", {31'b0, bus.busy}, 32'd0);
    chk("flush fix lo", bus.lo, 32'hFFFF_FFFA);

    // Back-to-back: second start issued in the done cycle
    run_op("b2b first", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    run_op("b2b second", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    // Reset mid-op at cycle 20 clears state without a clock edge
    start_op(2'b01, 32'd1000, 32'd1000);
    repeat (19) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midreset busy", {31'b0, bus.busy}, 32'd0);
    chk("midreset hi", bus.hi, 32'd0);
    chk("midreset lo", bus.lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_op("after reset", 2'b11, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
